// File: rtl/pc_fetch_unit.sv
// pc_fetch_unit: instruction-fetch stage.
// Owns the architectural PC and keeps at most one req/ack fetch to instruction
// memory outstanding. Presents {pc, instr, pc+4} to decode over valid/ready.
// A redirect reloads the PC. A fetch already in flight when the redirect
// arrives is allowed to complete, and its data is then dropped.
module pc_fetch_unit #(
    parameter int               XLEN     = 32,
    parameter logic [XLEN-1:0]  RESET_PC = '0,
    parameter logic [31:0]      NOP      = 32'h0000_0013
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            redirect,
    input  logic [XLEN-1:0] redirect_pc,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [31:0]     imem_rdata,
    output logic            if_valid,
    input  logic            if_ready,
    output logic [XLEN-1:0] if_pc,
    output logic [31:0]     if_instr,
    output logic [XLEN-1:0] if_pc_plus4
);

    // BOOT: one idle cycle after reset. REQ: fetch outstanding at pc.
    // HOLD: instruction presented to decode. DROP: wrong-path fetch still in flight.
    typedef enum logic [1:0] {
        BOOT = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        DROP = 2'd3
    } state_t;

    state_t          state_q;
    state_t          state_d;
    logic [XLEN-1:0] pc_q;
    logic [XLEN-1:0] pend_pc_q;
    logic [XLEN-1:0] if_pc_q;
    logic [XLEN-1:0] if_pc4_q;
    logic [31:0]     if_instr_q;
    logic [XLEN-1:0] rd_tgt;
    logic [XLEN-1:0] pc_plus4;

    // Word-align an address. Instructions are always 4-byte aligned.
    function automatic logic [XLEN-1:0] align_word(input logic [XLEN-1:0] a);
        return a & ~XLEN'(3);
    endfunction

    // Sequential increment. The sum wraps modulo 2^XLEN, so 0xFFFF_FFFC is followed by 0.
    function automatic logic [XLEN-1:0] next_word(input logic [XLEN-1:0] a);
        return a + XLEN'(4);
    endfunction

    assign rd_tgt   = align_word(redirect_pc);
    assign pc_plus4 = next_word(pc_q);

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= BOOT;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            BOOT: state_d = REQ;
            REQ: begin
                if (imem_ack) begin
                    state_d = redirect ? REQ : HOLD;
                end else if (redirect) begin
                    state_d = DROP;
                end
            end
            DROP: begin
                if (imem_ack) begin
                    state_d = REQ;
                end
            end
            HOLD: begin
                if (redirect || if_ready) begin
                    state_d = REQ;
                end
            end
            default: state_d = BOOT;
        endcase
    end

    // Output decode. The fetch address always tracks pc_q, which stays constant while a request waits.
    always_comb begin
        imem_req  = 1'b0;
        if_valid  = 1'b0;
        imem_addr = pc_q;
        unique case (state_q)
            REQ, DROP: imem_req = 1'b1;
            HOLD:      if_valid = 1'b1;
            default:   ;
        endcase
    end

    // PC, pending redirect target and decode payload registers
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q       <= RESET_PC;
            pend_pc_q  <= '0;
            if_pc_q    <= '0;
            if_pc4_q   <= '0;
            if_instr_q <= NOP;
        end else begin
            unique case (state_q)
                REQ: begin
                    if (imem_ack) begin
                        if (redirect) begin
                            // The returned word is from the wrong path. Drop it and refetch at the target.
                            pc_q <= rd_tgt;
                        end else begin
                            if_instr_q <= imem_rdata;
                            if_pc_q    <= pc_q;
                            if_pc4_q   <= pc_plus4;
                            pc_q       <= pc_plus4;
                        end
                    end else if (redirect) begin
                        pend_pc_q <= rd_tgt;
                    end
                end
                DROP: begin
                    if (imem_ack) begin
                        // A redirect that arrives in the same cycle as the ack takes priority over the parked one.
                        pc_q <= redirect ? rd_tgt : pend_pc_q;
                    end else if (redirect) begin
                        pend_pc_q <= rd_tgt;
                    end
                end
                HOLD: begin
                    if (redirect) begin
                        pc_q       <= rd_tgt;
                        if_instr_q <= NOP;
                    end
                end
                default: ;
            endcase
        end
    end

    assign if_pc       = if_pc_q;
    assign if_pc_plus4 = if_pc4_q;
    assign if_instr    = if_instr_q;

endmodule
